// File: rtl/hazard_forward_unit_if.sv
// Hazard unit bus: pipeline register fields in, forward selects / stall / scoreboard count out.
// Master is the pipeline side; slave is the hazard unit.
interface hazard_forward_unit_if #(
  parameter int REG_AW = 5,
  parameter int NUM_RS = 2
);
  logic                     id_valid;
  logic [NUM_RS*REG_AW-1:0] id_rs;
  logic [REG_AW-1:0]        id_rd;
  logic                     id_regwrite;
  logic [NUM_RS*REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0]        idex_rd;
  logic                     idex_regwrite;
  logic                     idex_memread;
  logic                     idex_long;
  logic [REG_AW-1:0]        exmem_rd;
  logic                     exmem_regwrite;
  logic [REG_AW-1:0]        memwb_rd;
  logic                     memwb_regwrite;
  logic                     long_wb_valid;
  logic [REG_AW-1:0]        long_wb_rd;
  logic [NUM_RS*2-1:0]      fwd_sel;
  logic                     stall;
  logic                     bubble;
  logic [REG_AW:0]          sb_count;

  modport master (
    output id_valid, id_rs, id_rd, id_regwrite, ex_rs,
           idex_rd, idex_regwrite, idex_memread, idex_long,
           exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
           long_wb_valid, long_wb_rd,
    input  fwd_sel, stall, bubble, sb_count
  );

  modport slave (
    input  id_valid, id_rs, id_rd, id_regwrite, ex_rs,
           idex_rd, idex_regwrite, idex_memread, idex_long,
           exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
           long_wb_valid, long_wb_rd,
    output fwd_sel, stall, bubble, sb_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX forwarding selects, load-use stall FSM and long-latency register scoreboard.
// Forwarding/stall are combinational; scoreboard lookups see state from the previous edge.
module hazard_forward_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_RS     = 2,
  parameter int LOAD_STALL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_forward_unit_if.slave hz
);

  localparam int NumRegs = 1 << REG_AW;

  typedef enum logic {IDLE, LU_WAIT} luState_t;

  luState_t             luState, luStateNext;
  logic [3:0]           luCnt, luCntNext;
  logic [NumRegs-1:0]   pending, pendingNext;
  logic [REG_AW:0]      sbCount, sbCountNext;
  logic [NUM_RS*2-1:0]  fwdSel;
  logic                 luHit, sbHit, stallInt;

  // Forwarding: the younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwdSel = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (hz.exmem_regwrite && (hz.exmem_rd != '0) &&
          (hz.exmem_rd == hz.ex_rs[k*REG_AW +: REG_AW]))
        fwdSel[k*2 +: 2] = 2'b10;
      else if (hz.memwb_regwrite && (hz.memwb_rd != '0) &&
               (hz.memwb_rd == hz.ex_rs[k*REG_AW +: REG_AW]))
        fwdSel[k*2 +: 2] = 2'b01;
    end
  end

  always_comb begin
    luHit = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (hz.id_rs[k*REG_AW +: REG_AW] == hz.idex_rd)
        luHit = 1'b1;
    end
    luHit = luHit & hz.id_valid & hz.idex_memread & hz.idex_regwrite & (hz.idex_rd != '0);
  end

  // luCnt holds the LU_WAIT cycles still to come, including the current one.
  always_comb begin
    luStateNext = luState;
    luCntNext   = luCnt;
    case (luState)
      IDLE: begin
        if (luHit && (LOAD_STALL > 1)) begin
          luStateNext = LU_WAIT;
          luCntNext   = 4'(LOAD_STALL - 1);
        end
      end
      LU_WAIT: begin
        luCntNext = luCnt - 4'd1;
        if (luCntNext == 4'd0)
          luStateNext = IDLE;
      end
      default: begin
        luStateNext = IDLE;
        luCntNext   = '0;
      end
    endcase
  end

  // Set after clear so a simultaneous re-issue keeps the register pending.
  always_comb begin
    pendingNext = pending;
    if (hz.long_wb_valid && (hz.long_wb_rd != '0))
      pendingNext[hz.long_wb_rd] = 1'b0;
    if (hz.idex_long && hz.idex_regwrite && (hz.idex_rd != '0))
      pendingNext[hz.idex_rd] = 1'b1;
    pendingNext[0] = 1'b0;
    sbCountNext = '0;
    for (int i = 0; i < NumRegs; i++)
      sbCountNext = sbCountNext + {{REG_AW{1'b0}}, pendingNext[i]};
  end

  always_comb begin
    sbHit = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (pending[hz.id_rs[k*REG_AW +: REG_AW]])
        sbHit = 1'b1;
    end
    if (hz.id_regwrite && pending[hz.id_rd])
      sbHit = 1'b1;
    sbHit = sbHit & hz.id_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luState <= IDLE;
      luCnt   <= '0;
      pending <= '0;
      sbCount <= '0;
    end else begin
      luState <= luStateNext;
      luCnt   <= luCntNext;
      pending <= pendingNext;
      sbCount <= sbCountNext;
    end
  end

  assign stallInt    = rst_n & (luHit | ((luState == LU_WAIT) & hz.id_valid) | sbHit);
  assign hz.stall    = stallInt;
  assign hz.bubble   = stallInt;
  assign hz.fwd_sel  = fwdSel;
  assign hz.sb_count = sbCount;

endmodule
